// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prog_loader                                                |
// | Description : Host-side program loader for the core. Streams instruction |
// |               words into instruction RAM from a base address, pulses the |
// |               core Start, counts run cycles until Halt and reports Done, |
// |               Cycle_Count and a sticky Error (overflow or timeout).      |
// | Ports       : CLK, Reset_n (async, active low)                           |
// |               Cmd_Go/Base_Addr      - begin a load at a base address     |
// |               In_Valid/In_Ready/In_Word/In_Last - word stream handshake  |
// |               Wr_En/Wr_Addr/Wr_Data - instruction RAM write port         |
// |               Start/Start_Addr/Halt - core start/finish interface        |
// |               Busy/Done/Error/Cycle_Count - status to the host           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prog_loader #(
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 9,
  parameter int START_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 0
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               Cmd_Go,
  input  logic [ADDR_W-1:0]  Base_Addr,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [INSTR_W-1:0] In_Word,
  input  logic               In_Last,
  output logic               Wr_En,
  output logic [ADDR_W-1:0]  Wr_Addr,
  output logic [INSTR_W-1:0] Wr_Data,
  output logic               Start,
  output logic [ADDR_W-1:0]  Start_Addr,
  input  logic               Halt,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [CNT_W-1:0]   Cycle_Count
);

  localparam int             c_SC_W    = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [c_SC_W-1:0] c_SC_LAST = c_SC_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_MAX     = CNT_W'(MAX_CYCLES);
  localparam bit             c_TO_EN   = (MAX_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_startAddr;
  logic [c_SC_W-1:0]   r_startCnt;
  logic                r_wrEn;
  logic [ADDR_W-1:0]   r_wrAddr;
  logic [INSTR_W-1:0]  r_wrData;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [CNT_W-1:0]    r_cnt;

  logic w_accept;
  logic w_beat;
  logic w_overflow;
  logic w_timeout;
  logic w_runEnd;

  // In_Ready is a pure decode of the state register, so it drops with reset.
  assign w_beat     = (r_state == S_LOAD) && In_Valid;
  // A non-last word at the top address has nowhere for its successor to go.
  assign w_overflow = w_beat && !In_Last && (r_ptr == {ADDR_W{1'b1}});
  // Timeout is evaluated on the cycle the count already equals the limit;
  // Halt in that same cycle takes priority.
  assign w_timeout  = c_TO_EN && (r_cnt == c_MAX);
  assign w_runEnd   = (r_state == S_RUN) && (Halt || w_timeout);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Cmd_Go) begin
          w_next   = S_LOAD;
          w_accept = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_beat && In_Last)  w_next = S_START;
        else if (w_overflow)    w_next = S_DONE;
      end
      S_START: begin
        if (r_startCnt == c_SC_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_runEnd) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr       <= '0;
      r_startAddr <= '0;
      r_startCnt  <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_busy <= (w_next == S_LOAD) || (w_next == S_START) || (w_next == S_RUN);
      r_wrEn <= w_beat;

      if (w_accept) begin
        r_ptr       <= Base_Addr;
        r_startAddr <= Base_Addr;
      end else if (w_beat) begin
        r_wrAddr <= r_ptr;
        r_wrData <= In_Word;
        r_ptr    <= r_ptr + ADDR_W'(1);
      end

      if (r_state == S_START && r_startCnt != c_SC_LAST)
        r_startCnt <= r_startCnt + c_SC_W'(1);
      else
        r_startCnt <= '0;

      if (w_accept) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
        r_cnt   <= '0;
      end else begin
        if (w_overflow || w_runEnd) r_done <= 1'b1;
        if (w_overflow || (w_runEnd && !Halt)) r_error <= 1'b1;
        // The cycle that ends the run (Halt or timeout) is not counted.
        if (r_state == S_RUN && !w_runEnd && r_cnt != {CNT_W{1'b1}})
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign In_Ready    = (r_state == S_LOAD);
  assign Start       = (r_state == S_START);
  assign Start_Addr  = r_startAddr;
  assign Wr_En       = r_wrEn;
  assign Wr_Addr     = r_wrAddr;
  assign Wr_Data     = r_wrData;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Error       = r_error;
  assign Cycle_Count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_prog_loader                                             |
// | Description : Self-checking bench for prog_loader. Table of per-cycle    |
// |               vectors for load/start/run, plus directed sequences for    |
// |               long run, overflow, timeout, restart and async reset.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Cmd_Go;
  logic [7:0]  Base_Addr;
  logic        In_Valid;
  logic        In_Ready;
  logic [8:0]  In_Word;
  logic        In_Last;
  logic        Wr_En;
  logic [7:0]  Wr_Addr;
  logic [8:0]  Wr_Data;
  logic        Start;
  logic [7:0]  Start_Addr;
  logic        Halt;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] Cycle_Count;

  prog_loader #(
    .ADDR_W(8), .INSTR_W(9), .START_CYCLES(2), .CNT_W(16), .MAX_CYCLES(50)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Cmd_Go(Cmd_Go), .Base_Addr(Base_Addr),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Word(In_Word), .In_Last(In_Last),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Start(Start), .Start_Addr(Start_Addr), .Halt(Halt),
    .Busy(Busy), .Done(Done), .Error(Error), .Cycle_Count(Cycle_Count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        go;
    logic [7:0]  base;
    logic        v;
    logic [8:0]  w;
    logic        last;
    logic        halt;
    logic        eWr;
    logic [7:0]  eAddr;
    logic [8:0]  eData;
    logic        eStart;
    logic [7:0]  eSA;
    logic        eRdy;
    logic        eBusy;
    logic        eDone;
    logic        eErr;
    logic [15:0] eCnt;
  } vec_t;

  localparam int N_VEC  = 15;
  localparam int RUN_AT = 6;

  vec_t tbl [N_VEC];
  int   nVec = 0;
  int   nMis = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    nVec++;
    if (got !== want) begin
      nMis++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Cmd_Go = 1'b0; In_Valid = 1'b0; In_Last = 1'b0; Halt = 1'b0;
  endtask

  function automatic logic [63:0] allOuts();
    return {17'd0, Wr_En, Wr_Addr, Wr_Data, Start, Start_Addr,
            In_Ready, Busy, Done, Error, Cycle_Count};
  endfunction

  // Halt rises 37 cycles after Start falls; those 37 cycles are counted.
  task automatic runLong();
    idle();
    repeat (37) step();
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    chk("run37_cnt", {48'd0, Cycle_Count}, 64'd37);
    chk("run37_flags", {61'd0, Done, Error, Busy}, {61'd0, 3'b100});
  endtask

  initial begin
    logic [46:0] act, exp, msk;
    logic        seen;
    int          n;

    //           go   base   v    w       last halt eWr  eAddr  eData   eSt  eSA    rdy  bsy  dn   er   cnt
    tbl[0]  = '{1'b1, 8'h10, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 9'h1A5, 1'b0, 1'b0, 1'b1, 8'h10, 9'h1A5, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 9'h003, 1'b0, 1'b0, 1'b1, 8'h11, 9'h003, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1, 8'h12, 9'h1FF, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    // restart from DONE with gapped valid 1-0-0-1-1, Halt held through START
    tbl[6]  = '{1'b1, 8'h40, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 9'h055, 1'b0, 1'b0, 1'b1, 8'h40, 9'h055, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 9'h0AA, 1'b0, 1'b0, 1'b1, 8'h41, 9'h0AA, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 9'h100, 1'b1, 1'b0, 1'b1, 8'h42, 9'h100, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'h00, 9'h000, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'h00, 9'h000, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'h00, 9'h000, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};

    Reset_n = 1'b1; Base_Addr = 8'h00; In_Word = 9'h000;
    idle();

    // asynchronous reset asserted between edges
    #2 Reset_n = 1'b0;
    #1 chk("reset_async", allOuts(), 64'd0);
    @(negedge CLK) Reset_n = 1'b1;
    step();
    chk("reset_idle", {62'd0, In_Ready, Busy}, 64'd0);

    for (int i = 0; i < N_VEC; i++) begin
      if (i == RUN_AT) runLong();
      Cmd_Go = tbl[i].go;   Base_Addr = tbl[i].base;
      In_Valid = tbl[i].v;  In_Word = tbl[i].w;
      In_Last = tbl[i].last; Halt = tbl[i].halt;
      step();
      act = {Wr_En, Wr_Addr, Wr_Data, Start, Start_Addr, In_Ready, Busy, Done, Error, Cycle_Count};
      exp = {tbl[i].eWr, tbl[i].eAddr, tbl[i].eData, tbl[i].eStart, tbl[i].eSA,
             tbl[i].eRdy, tbl[i].eBusy, tbl[i].eDone, tbl[i].eErr, tbl[i].eCnt};
      msk = '1;
      if (!tbl[i].eWr) msk[45:29] = '0;
      chk($sformatf("row%0d", i), {17'd0, act & msk}, {17'd0, exp & msk});
    end
    idle();

    // overflow: base 0xFE, third word must not be written, no Start
    Cmd_Go = 1'b1; Base_Addr = 8'hFE;
    step();
    Cmd_Go = 1'b0; In_Valid = 1'b1; In_Word = 9'h111;
    step();
    chk("ovf_w0", {45'd0, Wr_En, Wr_Addr, Wr_Data, Error}, {45'd0, 1'b1, 8'hFE, 9'h111, 1'b0});
    In_Word = 9'h122;
    step();
    chk("ovf_w1", {45'd0, Wr_En, Wr_Addr, Wr_Data, Error}, {45'd0, 1'b1, 8'hFF, 9'h122, 1'b1});
    chk("ovf_flags", {60'd0, Done, Busy, In_Ready, Start}, {60'd0, 4'b1000});
    In_Word = 9'h133; In_Last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ovf_quiet%0d", k), {61'd0, Wr_En, Start, Done}, {61'd0, 3'b001});
    end
    idle();

    // timeout at MAX_CYCLES = 50
    Cmd_Go = 1'b1; Base_Addr = 8'h20;
    step();
    Cmd_Go = 1'b0; In_Valid = 1'b1; In_Word = 9'h0C3; In_Last = 1'b1;
    step();
    idle();
    n = 0;
    while (!Done && n < 200) begin
      step();
      n++;
    end
    chk("tmo_done", {63'd0, Done}, 64'd1);
    chk("tmo_cnt", {48'd0, Cycle_Count}, 64'd50);
    chk("tmo_err_busy", {62'd0, Error, Busy}, {62'd0, 2'b10});

    // restart clears status on the accepting edge
    Cmd_Go = 1'b1; Base_Addr = 8'h33;
    step();
    Cmd_Go = 1'b0;
    chk("restart", {36'd0, Done, Error, Cycle_Count, Busy, In_Ready, Start_Addr},
                   {36'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 8'h33});
    In_Valid = 1'b1; In_Word = 9'h0AB;
    step();
    In_Valid = 1'b0;

    // reset mid-load: outputs clear immediately, no Start afterwards
    #3 Reset_n = 1'b0;
    #1 chk("reset_midop", allOuts(), 64'd0);
    @(negedge CLK) Reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | Start | In_Ready | Busy | Wr_En;
    end
    chk("post_reset_quiet", {63'd0, seen}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side counterpart to the core's fetch/start interface.
- Accepts a stream of 9-bit instruction words over a valid/ready handshake and writes them into instruction RAM from a base address.
- Then pulses the core's Start with Start_Addr, counts execution cycles until the core raises Halt, and reports Done, cycle count and error status.
- Sits between the test host and the core top level.

Parameters:
ADDR_W, 8, instruction memory address width (matches the 8-bit PC)
INSTR_W, 9, instruction word width
START_CYCLES, 2, cycles Start is held high (at least 1)
CNT_W, 16, cycle counter width
MAX_CYCLES, 0, run timeout in cycles; 0 disables the timeout

Ports:
CLK  input  1  clock, all state updates on posedge
Reset_n  input  1  asynchronous active-low reset
Cmd_Go  input  1  single-cycle command that begins a load; sampled in IDLE or DONE only
Base_Addr  input  ADDR_W  load base and start address, captured when Cmd_Go is accepted
In_Valid  input  1  host word valid
In_Ready  output  1  loader accepts a word
In_Word  input  INSTR_W  instruction word
In_Last  input  1  marks the final word of the program
Wr_En  output  1  instruction RAM write enable
Wr_Addr  output  ADDR_W  instruction RAM write address
Wr_Data  output  INSTR_W  instruction RAM write data
Start  output  1  to core Start
Start_Addr  output  ADDR_W  to core Start_Addr
Halt  input  1  core finished
Busy  output  1  high in LOAD, START and RUN
Done  output  1  sticky completion flag
Error  output  1  sticky; set on address overflow or timeout
Cycle_Count  output  CNT_W  run cycles, counted from the first cycle after Start drops to the cycle Halt is seen

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State goes to IDLE.
  - All outputs are 0: In_Ready, Wr_En, Wr_Addr, Wr_Data, Start, Start_Addr, Busy, Done, Error, Cycle_Count.
  - Internal write pointer and start counter are 0.
- Reset mid-operation: the load or run is abandoned. RAM words already written stay. No Start pulse is issued after reset releases.
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE / DONE:
  - In_Ready=0.
  - Cmd_Go=1 -> LOAD. Capture Base_Addr into the pointer and Start_Addr. Clear Done, Error and Cycle_Count in the same edge.
- LOAD:
  - In_Ready=1 and Busy=1.
  - A beat is In_Valid & In_Ready.
  - Each beat registers Wr_En=1, Wr_Addr=pointer and Wr_Data=In_Word on the next edge, so a write appears 1 cycle after the handshake. Then pointer increments by 1.
  - Wr_En=0 in any cycle without a preceding beat.
  - Beat with In_Last=1 -> START. A single-word program is legal.
  - Overflow: a beat at pointer = 2^ADDR_W-1 with In_Last=0 still writes that word, then sets Error=1 and Done=1 and goes to DONE. No Start is issued. A last word landing exactly at the top address is not an error.
  - In_Valid=0 in LOAD: state holds indefinitely with no timeout.
- START:
  - Start=1 for exactly START_CYCLES consecutive cycles, with Start_Addr stable.
  - In_Ready=0 and Wr_En=0.
  - Halt is ignored during START.
  - After the last Start cycle -> RUN with Start=0.
- RUN:
  - Cycle_Count increments by 1 per cycle and saturates at all-ones.
  - Halt=1 -> DONE, Done=1. The cycle in which Halt is seen is not counted.
  - If MAX_CYCLES != 0 and Cycle_Count reaches MAX_CYCLES without Halt: Error=1, Done=1, go to DONE.
  - Halt and timeout in the same cycle: Halt wins, Error=0.
- DONE:
  - Done, Error and Cycle_Count hold until reset or the next accepted Cmd_Go.
- Cmd_Go outside IDLE/DONE is ignored.
- Busy = state is LOAD, START or RUN, registered.

Test Plan:
- Reset: Reset_n=0 asserted mid-clock -> every output is 0 immediately, without waiting for a clock edge; after release the state is IDLE and In_Ready=0.
- Basic load: Cmd_Go with Base_Addr=0x10, then 3 beats 0x1A5, 0x003, 0x1FF (last) -> writes to 0x10, 0x11, 0x12, each 1 cycle after its beat; Start high 2 cycles with Start_Addr=0x10.
- Backpressure gaps: In_Valid toggled 1-0-0-1-1 -> writes occur only for the 3 valid cycles, at consecutive addresses, with no extra Wr_En.
- Run count: Halt raised 37 cycles after Start falls -> Cycle_Count=37, Done=1, Error=0, Busy=0.
- Overflow: Base_Addr=0xFE, 3 words, last on the 3rd -> writes at 0xFE and 0xFF, Error=1, Done=1, Start never asserted, 3rd word not written.
- Timeout / restart: MAX_CYCLES=50, no Halt -> Error=1 and Cycle_Count=50. A following Cmd_Go clears Done, Error and Cycle_Count on the same edge and re-enters LOAD.
